uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// Serial UART transmitter: the outbound counterpart of uart_rx. Accepts bytes over a
// valid/ready handshake into a small internal FIFO and serialises them as 8N1 frames
// (start bit 0, 8 data bits LSB first, stop bit(s) 1) on a single line. A board top
// drives o_tx_data straight to an output pin (e.g. PIN_2) at the same baud as uart_rx.
// PARAMETERS
// BAUD_MULT   1666  clock cycles per bit (16 MHz / 1666 ~= 9600 baud); must be >= 2
// FIFO_DEPTH  4     byte FIFO entries; power of two, >= 2
// STOP_BITS   1     stop bits per frame; 1 or 2
// PORTS
// i_uart_clk    in   1                   system clock; all logic on rising edge
// i_rst_n       in   1                   synchronous active-low reset
// i_tx_byte     in   8                   byte to transmit
// i_tx_valid    in   1                   i_tx_byte valid this cycle
// o_tx_ready    out  1                   FIFO can accept a byte (count < FIFO_DEPTH)
// o_tx_data     out  1                   serial line, registered, idle high
// o_tx_active   out  1                   high while a frame is on the line
// o_fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes waiting (excludes the byte in flight)
// BEHAVIOUR
// - Reset (i_rst_n low at an edge): o_tx_data=1, o_tx_active=0, o_fifo_count=0,
//   o_tx_ready=1, FSM=IDLE, baud/bit counters=0; FIFO contents discarded.
// - Push: byte written when i_tx_valid && o_tx_ready at an edge. With o_tx_ready low,
//   i_tx_valid is ignored; producer holds the byte. o_tx_ready is decoded from the
//   registered count, no combinational path from i_tx_valid.
// - Pop: FSM takes the FIFO head in IDLE when count!=0, or at the final cycle of the
//   last stop bit when count!=0. Push and pop on the same edge: count unchanged.
// - FSM: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//   IDLE: line 1. On pop: load shift reg, o_tx_data<=0, o_tx_active<=1, goto START.
//   START: hold 0 for BAUD_MULT cycles, then drive bit0, goto DATA.
//   DATA: each bit held exactly BAUD_MULT cycles, LSB first; after bit7 drive 1, goto STOP.
//   STOP: hold 1 for STOP_BITS*BAUD_MULT cycles; then pop->START (no idle gap) or
//     IDLE with o_tx_active<=0.
// - Latency: byte pushed at edge E into empty FIFO while IDLE -> line falls at E+1.
//   Frame length exactly (9+STOP_BITS)*BAUD_MULT cycles; back-to-back frames abut.
// - Baud counter counts 0..BAUD_MULT-1, width $clog2(BAUD_MULT); it wraps at bit
//   boundaries only. FIFO pointers wrap modulo FIFO_DEPTH; count saturates by
//   construction (no push when full, no pop when empty).
// - Reset mid-frame: line returns to 1 at the reset edge; the partial frame is abandoned,
//   not resumed. After release, the FSM waits in IDLE for a new push.
// - i_tx_byte is sampled only on a push; later changes do not affect queued data.
// TESTING (sim: BAUD_MULT=3, FIFO_DEPTH=4, STOP_BITS=1)
// 1 Push 0x41 once -> starting E+1: 0 x3, bits 1,0,0,0,0,0,1,0 x3 each, 1 x3;
//   o_tx_active high 30 cycles, then low.
// 2 Push 0x55 then 0xAA on consecutive cycles -> 60 contiguous active cycles; second
//   start bit immediately follows the first stop bit.
// 3 Hold valid with 6 bytes -> 5 accepted in 5 cycles (first popped at E+1), o_tx_ready
//   low with count=4; 6th accepted on the cycle after frame 1's stop bit ends.
// 4 Reset during DATA bit 3 -> next edge: o_tx_data=1, active=0, count=0, ready=1;
//   the next push sends a complete, correct frame.
// 5 STOP_BITS=2, push 0xFF -> 0 x3, eight 1s x3, stop 1 x6; active 33 cycles.
// 6 Loopback into uart_rx (same BAUD_MULT): stream 0x00..0xFF -> all 256 received in order.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes enter a small FIFO over valid/ready and leave
// as start / 8 data LSB first / stop frames on a registered, idle-high line.
module uart_tx #(
  parameter int unsigned BAUD_MULT  = 1666,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          i_uart_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    i_tx_byte,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic                          o_tx_data,
  output logic                          o_tx_active,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned CW      = $clog2(BAUD_MULT);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned BL      = BAUD_MULT - 1;
  localparam int unsigned SL      = STOP_BITS - 1;
  localparam int unsigned FD      = FIFO_DEPTH;
  localparam logic [CW-1:0] BAUD_LAST = BL[CW-1:0];
  localparam logic [2:0]    STOP_LAST = SL[2:0];
  localparam logic [AW:0]   FULL      = FD[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          stop_end;

  assign o_tx_ready   = (count != FULL);
  assign o_fifo_count = count;

  always_comb begin
    push     = i_tx_valid && o_tx_ready;
    bit_end  = (baud_cnt == BAUD_LAST);
    stop_end = bit_end && (bit_cnt == STOP_LAST);
    pop      = (count != '0) && ((state == IDLE) || ((state == STOP) && stop_end));
  end

  always_ff @(posedge i_uart_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_tx_byte;
  end

  always_ff @(posedge i_uart_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_tx_data   <= 1'b1;
      o_tx_active <= 1'b0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg       <= fifo_mem[rd_ptr];
            o_tx_data   <= 1'b0;
            o_tx_active <= 1'b1;
            baud_cnt    <= '0;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            o_tx_data <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt   <= '0;
              o_tx_data <= 1'b1;
              state     <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              o_tx_data <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_cnt is reused here to count stop bits
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shreg     <= fifo_mem[rd_ptr];
                o_tx_data <= 1'b0;
                state     <= START;
              end else begin
                o_tx_active <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_MULT=3: cycle-exact frame checks plus a
// line decoder that reassembles bytes for the queued / streamed cases.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte1, byte2;
  logic       v1, v2;
  logic       rdy1, rdy2, data1, data2, act1, act2;
  logic [2:0] cnt1, cnt2;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx #(.BAUD_MULT(3), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_tx_byte(byte1), .i_tx_valid(v1),
    .o_tx_ready(rdy1), .o_tx_data(data1), .o_tx_active(act1), .o_fifo_count(cnt1)
  );

  uart_tx #(.BAUD_MULT(3), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_tx_byte(byte2), .i_tx_valid(v2),
    .o_tx_ready(rdy2), .o_tx_data(data2), .o_tx_active(act2), .o_fifo_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first cycle of the start bit; leaves one cycle after the frame.
  task automatic check_frame(input string tag, input logic [7:0] b, input int nstop, input int sel);
    int   bi;
    logic e;
    for (int k = 0; k < (9 + nstop) * 3; k++) begin
      bi = k / 3;
      if (bi == 0)      e = 1'b0;
      else if (bi <= 8) e = b[bi-1];
      else              e = 1'b1;
      check(tag, (sel != 0) ? data2 : data1, e);
      check({tag, "_act"}, (sel != 0) ? act2 : act1, 1);
      tick();
    end
  endtask

  // Line decoder for dut1: samples the first cycle of every bit period.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #2;
      if (data1 === 1'b0) begin
        for (int n = 0; n < 8; n++) begin
          repeat (3) @(posedge clk);
          #2;
          b[n] = data1;
        end
        repeat (3) @(posedge clk);
        #2;
        check("stop_bit", data1, 1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3 [6];
    int         n;
    t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0; byte1 = '0; byte2 = '0;
    repeat (3) tick();
    check("rst_data", data1, 1);
    check("rst_act",  act1,  0);
    check("rst_cnt",  cnt1,  0);
    check("rst_rdy",  rdy1,  1);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single byte, line falls one cycle after the push
    byte1 = 8'h41; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("t1_cnt_after_push", cnt1, 1);
    check("t1_line_idle", data1, 1);
    tick();
    check("t1_cnt_popped", cnt1, 0);
    check_frame("t1_frame", 8'h41, 1, 0);
    check("t1_act_end", act1, 0);
    check("t1_line_end", data1, 1);
    repeat (5) tick();

    // 2: back-to-back frames abut
    byte1 = 8'h55; v1 = 1'b1;
    tick();
    byte1 = 8'hAA;
    tick();
    v1 = 1'b0;
    check("t2_cnt", cnt1, 1);
    check_frame("t2_f1", 8'h55, 1, 0);
    check_frame("t2_f2", 8'hAA, 1, 0);
    check("t2_act_end", act1, 0);
    repeat (5) tick();

    // 3: hold valid with six bytes
    rx_q.delete();
    v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte1 = t3[i];
      tick();
      if (i == 1) begin
        check("t3_first_pop_act", act1, 1);
        check("t3_first_pop_line", data1, 0);
      end
    end
    check("t3_cnt_full", cnt1, 4);
    check("t3_rdy_low", rdy1, 0);
    byte1 = t3[5];
    n = 0;
    while (!rdy1 && n < 100) begin
      tick();
      n++;
    end
    check("t3_wait_cycles", n, 27);
    tick();
    v1 = 1'b0;
    check("t3_cnt_refill", cnt1, 4);
    n = 0;
    while (rx_q.size() < 6 && n < 1000) begin
      tick();
      n++;
    end
    check("t3_rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t3_rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, t3[i]);
    repeat (10) tick();

    // 4: reset in the middle of data bit 3 with another byte queued
    byte1 = 8'h35; v1 = 1'b1;
    tick();
    byte1 = 8'h99;
    tick();
    v1 = 1'b0;
    repeat (13) tick();
    check("t4_bit3", data1, 0);
    check("t4_cnt_queued", cnt1, 1);
    rst_n = 1'b0;
    tick();
    check("t4_rst_data", data1, 1);
    check("t4_rst_act",  act1,  0);
    check("t4_rst_cnt",  cnt1,  0);
    check("t4_rst_rdy",  rdy1,  1);
    rst_n = 1'b1;
    repeat (40) tick();
    check("t4_no_resume_data", data1, 1);
    check("t4_no_resume_act",  act1,  0);
    rx_q.delete();
    byte1 = 8'hC3; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    check_frame("t4_frame", 8'hC3, 1, 0);
    check("t4_act_end", act1, 0);
    repeat (5) tick();

    // 5: two stop bits
    byte2 = 8'hFF; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    tick();
    check_frame("t5_frame", 8'hFF, 2, 1);
    check("t5_act_end", act2, 0);
    repeat (5) tick();

    // 6: stream every byte value through the handshake
    rx_q.delete();
    n = 0;
    for (int i = 0; i < 256; i++) begin
      byte1 = 8'(i);
      v1 = 1'b1;
      while (!rdy1 && n < 20000) begin
        tick();
        n++;
      end
      tick();
    end
    v1 = 1'b0;
    check("t6_push_budget", (n < 20000) ? 1 : 0, 1);
    n = 0;
    while (rx_q.size() < 256 && n < 10000) begin
      tick();
      n++;
    end
    check("t6_rx_count", rx_q.size(), 256);
    for (int i = 0; i < 256; i++)
      check("t6_rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
